// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one bit per CLK_tx cycle, frame = start, data LSB-first,
// optional parity, stop. Every output is driven straight from a flop.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK_tx,
    input  logic                  RST_tx,
    input  logic [DATA_WIDTH-1:0] P_DATA_tx,
    input  logic                  Data_valid_tx,
    input  logic                  PAR_EN_tx,
    input  logic                  PAR_TYP_tx,
    output logic                  TX_OUT_tx,
    output logic                  Busy_tx
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  par_en_reg;
    logic                  parity_reg;
    logic                  load;
    logic                  tx_next;
    logic                  busy_next;

    // Even parity is the XOR of the payload; odd parity is its complement.
    function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    always_ff @(posedge CLK_tx or posedge RST_tx) begin
        if (RST_tx) begin
            state      <= IDLE;
            cnt        <= '0;
            data_reg   <= '0;
            par_en_reg <= 1'b0;
            parity_reg <= 1'b0;
            TX_OUT_tx  <= 1'b1;
            Busy_tx    <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            TX_OUT_tx <= tx_next;
            Busy_tx   <= busy_next;
            if (load) begin
                data_reg   <= P_DATA_tx;
                par_en_reg <= PAR_EN_tx;
                parity_reg <= parity_of(P_DATA_tx, PAR_TYP_tx);
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load       = 1'b0;
        unique case (state)
            IDLE: begin
                if (Data_valid_tx) begin
                    state_next = START;
                    load       = 1'b1;
                end
            end
            START: begin
                state_next = DATA;
                cnt_next   = '0;
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    state_next = par_en_reg ? PARITY : STOP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            PARITY:  state_next = STOP;
            STOP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are precomputed from the state being entered so that the line
    // changes on the same edge as the state, with no decode after the flop.
    always_comb begin
        tx_next   = 1'b1;
        busy_next = (state_next != IDLE);
        unique case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = data_reg[cnt_next];
            PARITY:  tx_next = parity_reg;
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed and randomized bench for uart_tx_serializer; expected frames are built
// from the frame-format rules and compared bit by bit on the falling edge.
module tb_uart_tx_serializer;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] pdata;
    logic          valid;
    logic          pen;
    logic          ptyp;
    logic          tx;
    logic          busy;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    uart_tx_serializer #(.DATA_WIDTH(DW)) dut (
        .CLK_tx       (clk),
        .RST_tx       (rst),
        .P_DATA_tx    (pdata),
        .Data_valid_tx(valid),
        .PAR_EN_tx    (pen),
        .PAR_TYP_tx   (ptyp),
        .TX_OUT_tx    (tx),
        .Busy_tx      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line sequence: start 0, data LSB-first, parity if enabled, stop 1.
    function automatic void build(input logic [DW-1:0] d, input logic en, input logic typ);
        int ones;
        exp_q.delete();
        exp_q.push_back(1'b0);
        ones = 0;
        for (int i = 0; i < DW; i++) begin
            exp_q.push_back(d[i]);
            if (d[i]) ones++;
        end
        if (en) exp_q.push_back(((ones % 2) == 1) ^ typ);
        exp_q.push_back(1'b1);
    endfunction

    // mode 0: clean pulse; 1: random disturbance; 2: hold valid (back-to-back);
    // 3: directed disturbance (0xFF, parity enable toggled, valid pulse).
    task automatic run_frame(input logic [DW-1:0] d, input logic en, input logic typ,
                             input int mode, input bit aligned, input string name);
        if (!aligned) @(negedge clk);
        pdata = d; pen = en; ptyp = typ; valid = 1'b1;
        build(d, en, typ);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            chk({name, "_tx"}, {31'd0, tx}, {31'd0, exp_q[i]});
            chk({name, "_busy"}, {31'd0, busy}, 32'd1);
            case (mode)
                0: valid = 1'b0;
                1: begin
                    valid = 1'($urandom_range(0, 1));
                    pdata = DW'($urandom);
                    pen   = 1'($urandom_range(0, 1));
                    ptyp  = 1'($urandom_range(0, 1));
                end
                2: valid = 1'b1;
                3: begin
                    if (i == 3) begin
                        pdata = 8'hFF;
                        pen   = ~pen;
                        valid = 1'b1;
                    end else begin
                        valid = 1'b0;
                    end
                end
                default: valid = 1'b0;
            endcase
        end
        @(negedge clk);
        chk({name, "_idle_tx"}, {31'd0, tx}, 32'd1);
        chk({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
        if (mode != 2) begin
            valid = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk({name, "_gap_tx"}, {31'd0, tx}, 32'd1);
                chk({name, "_gap_busy"}, {31'd0, busy}, 32'd0);
            end
        end
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; pdata = '0; pen = 1'b0; ptyp = 1'b0;
        #1;
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        chk("reset_hold_tx", {31'd0, tx}, 32'd1);
        chk("reset_hold_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_tx", {31'd0, tx}, 32'd1);

        run_frame(8'hA5, 1'b0, 1'b0, 0, 1'b0, "a5_nopar");
        run_frame(8'hA5, 1'b1, 1'b0, 0, 1'b0, "a5_even");
        run_frame(8'h07, 1'b1, 1'b1, 0, 1'b0, "07_odd");
        run_frame(8'h07, 1'b1, 1'b0, 0, 1'b0, "07_even");
        run_frame(8'hA5, 1'b0, 1'b0, 3, 1'b0, "a5_disturb");

        run_frame(8'h3C, 1'b0, 1'b0, 2, 1'b0, "b2b_3c");
        run_frame(8'hC3, 1'b0, 1'b0, 0, 1'b1, "b2b_c3");

        // Reset during data bit 3: line index 4 of the frame.
        @(negedge clk);
        pdata = 8'hA5; pen = 1'b0; ptyp = 1'b0; valid = 1'b1;
        build(8'hA5, 1'b0, 1'b0);
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            valid = 1'b0;
            chk("pre_rst_tx", {31'd0, tx}, {31'd0, exp_q[i]});
        end
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", {31'd0, tx}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("after_rst_tx", {31'd0, tx}, 32'd1);
            chk("after_rst_busy", {31'd0, busy}, 32'd0);
        end

        for (int n = 0; n < 20; n++) begin
            run_frame(DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1, 1'b0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
